// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin, burst-locked arbiter that shares the single write port of a
// FIFO among NUM_IN valid/ready producer channels. A registered output stage
// drives the FIFO din/din_v pair and honours its din_r backpressure.
//
// Ports:
//   clock          sole clock
//   reset          asynchronous, active-low reset
//   io_in_din      requester data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   io_in_din_v    requester valid
//   io_in_din_r    requester ready (one-hot or zero)
//   io_fifo_din    word to FIFO
//   io_fifo_din_v  word valid to FIFO
//   io_fifo_din_r  FIFO ready
//   io_grant       one-hot current owner, zero when idle
//   io_busy        high while a channel owns the port
//
// Optional build macro FIFO_ARB_STATS_EN adds:
//   io_stall_clr   synchronous clear of the stall counter
//   io_stall_cnt   saturating count of cycles with din_v=1 and din_r=0

module fifo_write_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] io_in_din,
    input  logic [NUM_IN-1:0]            io_in_din_v,
    output logic [NUM_IN-1:0]            io_in_din_r,
    output logic [DATA_WIDTH-1:0]        io_fifo_din,
    output logic                         io_fifo_din_v,
    input  logic                         io_fifo_din_r,
    output logic [NUM_IN-1:0]            io_grant,
    output logic                         io_busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                         io_stall_clr,
    output logic [15:0]                  io_stall_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;

    logic [DATA_WIDTH-1:0]   ch_data [NUM_IN];
    logic                    out_free;
    logic                    owner_v;
    logic                    found;
    logic [IDX_W-1:0]        pick;
    int unsigned             idx;
    logic [CNT_W-1:0]        cnt_inc;

    // Unpack the flat requester data bus into per-channel words
    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign ch_data[i] = io_in_din[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign out_free = !valid_q || io_fifo_din_r;
    assign owner_v  = io_in_din_v[owner_q];
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Round-robin search starting just after the previous owner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            idx = (32'(last_q) + k) % NUM_IN;
            if (!found && io_in_din_v[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    // State and output-register update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_IN - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: arbitration in IDLE, burst transfer in LOCKED
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;

        // FIFO consumes the held word; a new accept below overrides this
        if (valid_q && io_fifo_din_r) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (owner_v && out_free) begin
                    data_d  = ch_data[owner_q];
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST_LEN)) begin
                        state_d = IDLE;
                    end
                end else if (!owner_v && out_free) begin
                    // Owner went quiet while the port could take data
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant/ready decode from the registered owner
    always_comb begin
        io_grant    = '0;
        io_in_din_r = '0;
        if (state_q == LOCKED) begin
            io_grant = NUM_IN'(1) << owner_q;
            if (out_free) begin
                io_in_din_r = NUM_IN'(1) << owner_q;
            end
        end
    end

    assign io_busy       = (state_q == LOCKED);
    assign io_fifo_din   = data_q;
    assign io_fifo_din_v = valid_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_q;

    // Saturating backpressure counter, clear wins over increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (io_stall_clr) begin
            stall_q <= '0;
        end else if (valid_q && !io_fifo_din_r && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign io_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Self-checking bench for fifo_write_arbiter (NUM_IN=4, DATA_WIDTH=32,
// BURST_LEN=4): directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.

module tb_fifo_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;

    logic              clock;
    logic              reset;
    logic [N*DW-1:0]   io_in_din;
    logic [N-1:0]      io_in_din_v;
    logic [N-1:0]      io_in_din_r;
    logic [DW-1:0]     io_fifo_din;
    logic              io_fifo_din_v;
    logic              io_fifo_din_r;
    logic [N-1:0]      io_grant;
    logic              io_busy;
`ifdef FIFO_ARB_STATS_EN
    logic              io_stall_clr;
    logic [15:0]       io_stall_cnt;
`endif

    fifo_write_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_din    (io_in_din),
        .io_in_din_v  (io_in_din_v),
        .io_in_din_r  (io_in_din_r),
        .io_fifo_din  (io_fifo_din),
        .io_fifo_din_v(io_fifo_din_v),
        .io_fifo_din_r(io_fifo_din_r),
        .io_grant     (io_grant),
        .io_busy      (io_busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .io_stall_clr (io_stall_clr),
        .io_stall_cnt (io_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Producers: channel i emits base[i], base[i]+1, ... one per handshake
    logic [DW-1:0] base [N];
    int unsigned   sent [N];

    // Reference model state (spec-level view)
    bit            m_locked;
    int            m_owner;
    int            m_last;
    int            m_cnt;
    bit            m_v;
    logic [DW-1:0] m_d;

    typedef struct {
        bit            rst;
        logic [N-1:0]  en;
        logic          fr;
        logic [N-1:0]  g;
        logic [N-1:0]  dr;
        logic          v;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [N-1:0] en, logic fr, logic [N-1:0] g,
                                logic [N-1:0] dr, logic v, logic [DW-1:0] d);
        vec_t r;
        r.rst = rst; r.en = en; r.fr = fr; r.g = g; r.dr = dr; r.v = v; r.d = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = int'(N) - 1;
        m_cnt    = 0;
        m_v      = 1'b0;
        m_d      = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        io_in_din_v   = '0;
        io_fifo_din_r = 1'b0;
        #1;
        check("rst_grant", 32'(io_grant), 32'd0);
        check("rst_din_r", 32'(io_in_din_r), 32'd0);
        check("rst_fifo_v", 32'(io_fifo_din_v), 32'd0);
        check("rst_fifo_din", io_fifo_din, 32'd0);
        check("rst_busy", 32'(io_busy), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        for (int i = 0; i < int'(N); i++) sent[i] = 0;
        model_reset();
    endtask

    // One clock cycle: drive, sample, compare with model, advance model
    task automatic step(input logic [N-1:0] en, input logic fr, input bit pulse,
                        output logic [N-1:0] s_g, output logic [N-1:0] s_dr,
                        output logic s_v, output logic [DW-1:0] s_d);
        int            acc;
        bit            free;
        bit            taken;
        bit            hit;
        int            c;
        logic [N-1:0]  exp_g;
        logic [N-1:0]  exp_dr;
        @(negedge clock);
        io_in_din_v = en;
        for (int i = 0; i < int'(N); i++) io_in_din[i*DW +: DW] = base[i] + DW'(sent[i]);
        io_fifo_din_r = fr;
        #1;
        s_g  = io_grant;
        s_dr = io_in_din_r;
        s_v  = io_fifo_din_v;
        s_d  = io_fifo_din;

        free   = !m_v || fr;
        exp_g  = m_locked ? (N'(1) << m_owner) : '0;
        exp_dr = (m_locked && free) ? (N'(1) << m_owner) : '0;
        check("mdl_grant", 32'(io_grant), 32'(exp_g));
        check("mdl_din_r", 32'(io_in_din_r), 32'(exp_dr));
        check("mdl_busy", 32'(io_busy), 32'(m_locked));
        check("mdl_fifo_v", 32'(io_fifo_din_v), 32'(m_v));
        check("mdl_fifo_din", io_fifo_din, m_d);

        if (pulse) begin
            #1 reset = 1'b0;
            #1;
            check("pulse_fifo_v", 32'(io_fifo_din_v), 32'd0);
            check("pulse_grant", 32'(io_grant), 32'd0);
            check("pulse_din_r", 32'(io_in_din_r), 32'd0);
            check("pulse_busy", 32'(io_busy), 32'd0);
            check("pulse_fifo_din", io_fifo_din, 32'd0);
            model_reset();
            #1 reset = 1'b1;
        end

        acc   = -1;
        free  = !m_v || fr;
        taken = m_v && fr;
        if (!m_locked) begin
            if (taken) m_v = 1'b0;
            hit = 1'b0;
            for (int k = 1; k <= int'(N); k++) begin
                c = (m_last + k) % int'(N);
                if (!hit && en[2'(c)]) begin
                    hit      = 1'b1;
                    m_locked = 1'b1;
                    m_owner  = c;
                    m_last   = c;
                    m_cnt    = 0;
                end
            end
        end else if (en[2'(m_owner)] && free) begin
            acc   = m_owner;
            m_d   = base[m_owner] + DW'(sent[m_owner]);
            m_v   = 1'b1;
            m_cnt = m_cnt + 1;
            if (m_cnt == int'(BL)) m_locked = 1'b0;
        end else begin
            if (taken) m_v = 1'b0;
            if (free && !en[2'(m_owner)]) m_locked = 1'b0;
        end

        @(posedge clock);
        if (acc >= 0) sent[acc] = sent[acc] + 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0]  g, dr;
        logic          v;
        logic [DW-1:0] d;
        logic [N-1:0]  prev_g;
        int            order[$];
        int            words[$];
        int            act;

        reset         = 1'b0;
        io_in_din     = '0;
        io_in_din_v   = '0;
        io_fifo_din_r = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        io_stall_clr  = 1'b0;
`endif
        base[0] = 32'h0000_1000;
        base[1] = 32'h0000_2000;
        base[2] = 32'h0000_00A0;
        base[3] = 32'h0000_4000;
        for (int i = 0; i < int'(N); i++) sent[i] = 0;
        model_reset();

        // ch2 alone, FIFO always ready: 4-word burst, bubble, regrant
        tbl.push_back(mk(1, 4'b0100, 1, 4'b0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 1, 32'hA0));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 1, 32'hA1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 1, 32'hA2));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 4'b0000, 1, 32'hA3));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 1, 32'hA4));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0100, 4'b0100, 1, 32'hA5));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 32'h0));
        // ch1 owner, FIFO stalls 5 cycles once the 2nd word is held
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 32'h2000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 4'b0000, 1, 32'h2001));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 32'h2001));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 32'h2002));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 32'h2003));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 32'h0));
        // ch3 drops valid after one word; ch1/ch2 pending -> ch1 next
        tbl.push_back(mk(1, 4'b1000, 1, 4'b0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 4'b1000, 1, 4'b1000, 4'b1000, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0110, 1, 4'b1000, 4'b1000, 1, 32'h4000));
        tbl.push_back(mk(0, 4'b0110, 1, 4'b0000, 4'b0000, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0110, 1, 4'b0010, 4'b0010, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0110, 1, 4'b0010, 4'b0010, 1, 32'h2000));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].en, tbl[i].fr, 1'b0, g, dr, v, d);
            check($sformatf("tbl%0d_grant", i), 32'(g), 32'(tbl[i].g));
            check($sformatf("tbl%0d_din_r", i), 32'(dr), 32'(tbl[i].dr));
            check($sformatf("tbl%0d_fifo_v", i), 32'(v), 32'(tbl[i].v));
            if (tbl[i].v) check($sformatf("tbl%0d_fifo_din", i), d, tbl[i].d);
        end

        // All channels valid: grant order 0,1,2,3,0 with 4 words each
        do_reset();
        prev_g = '0;
        for (int c = 0; c < 25; c++) begin
            step(4'b1111, 1'b1, 1'b0, g, dr, v, d);
            if (g != '0 && prev_g == '0) begin
                for (int i = 0; i < int'(N); i++) if (g[i]) order.push_back(i);
                words.push_back(0);
            end
            if (dr != '0 && words.size() > 0) words[words.size()-1] = words[words.size()-1] + 1;
            prev_g = g;
        end
        check("rr_lock_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            act = (i < order.size()) ? order[i] : -1;
            check($sformatf("rr_order%0d", i), 32'(act), 32'(i % 4));
            act = (i < words.size()) ? words[i] : -1;
            check($sformatf("rr_words%0d", i), 32'(act), 32'(BL));
        end

        // Asynchronous reset pulse mid-burst, then ch0 has first priority
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b1111, 1'b1, 1'b0, g, dr, v, d);
        step(4'b1111, 1'b1, 1'b1, g, dr, v, d);
        step(4'b1111, 1'b1, 1'b0, g, dr, v, d);
        check("post_rst_grant_ch0", 32'(g), 32'd1);

        // Randomized traffic and backpressure against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(~(N'($urandom) & N'($urandom)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0), g, dr, v, d);
            check("rand_din_r_onehot", 32'($countones(dr) <= 1), 32'd1);
        end

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        step(4'b0001, 1'b1, 1'b0, g, dr, v, d);
        step(4'b0001, 1'b1, 1'b0, g, dr, v, d);
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, 1'b0, g, dr, v, d);
        #1;
        check("stall_cnt_3", 32'(io_stall_cnt), 32'd3);
        io_stall_clr = 1'b1;
        step(4'b0000, 1'b0, 1'b0, g, dr, v, d);
        io_stall_clr = 1'b0;
        #1;
        check("stall_cnt_clr", 32'(io_stall_cnt), 32'd0);
        repeat (70000) @(posedge clock);
        #1;
        check("stall_cnt_sat", 32'(io_stall_cnt), 32'h0000_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
